mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, maximum cycles a request waits for mem_ack before abort (`MEM_TIMEOUT_EN` only).
REQ-002 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- RegWriteE  in  1  EX-stage register-write enable.
- MemWriteE  in  1  EX-stage store.
- ResultSrcE  in  2  writeback select: 00 ALU, 01 load, 10 PC+4, 11 treated as 00.
- RdE  in  5  destination register.
- ALUResultE  in  32  ALU result / memory address.
- WriteDataE  in  32  forwarded store data.
- PCPlus4E  in  32  link value.
- ALUResultM  out  32  EX/MEM ALU result, forwarded to EX.
- RdM  out  5  hazard-unit destination.
- RegWriteM  out  1  hazard-unit write enable.
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  request completed this cycle.
- mem_rdata  in  32  load data, valid with mem_ack.
- ResultW  out  32  writeback value, forwarded to EX.
- RdW  out  5  writeback destination.
- RegWriteW  out  1  register-file write enable.
- mem_err  out  1  sticky timeout flag.

Function
REQ-003 EX/MEM register: on each rising clk edge with StallM=0, captures all E inputs; with StallM=1, holds its contents.
REQ-004 Memory op: MemWriteM=1 (store), or ResultSrcM=01 (load); any other value is not a memory op and takes no memory cycles.
REQ-005 FSM states: IDLE, WAIT (plus ERR_WAIT when `MEM_TIMEOUT_EN` is defined).
REQ-006 IDLE: mem_req=1 combinationally when a memory op is present. mem_ack in the same cycle completes the op with no stall. Otherwise the FSM moves to WAIT.
REQ-007 WAIT: mem_req stays 1; mem_we, mem_addr and mem_wdata stay stable until mem_ack; mem_ack returns the FSM to IDLE.
REQ-008 Drive mem_addr = {ALUResultM[31:2], 2'b00}, mem_we = MemWriteM and mem_wdata = WriteDataM.
REQ-009 StallM = memory op present AND op not completing this cycle; StallM is combinational.
REQ-010 Ignore mem_ack while mem_req=0.
REQ-011 MEM/WB register: loads when the instruction in M completes (non-memory op, or mem_ack). While StallM=1 it loads a bubble (RegWriteW=0, RdW=0).
REQ-012 On a load completion, capture mem_rdata into MEM/WB.
REQ-013 ResultW is combinational from MEM/WB: select ALU result, load data or PC+4 per ResultSrcW; code 11 selects the ALU result.
REQ-014 RegWriteW is forced to 0 when RdW=0.
REQ-015 Back-to-back memory ops: the next op may assert mem_req in the cycle after the previous op's mem_ack.

Reset
REQ-016 rst_n=0 asynchronously clears the following: both pipeline registers, so all M/W outputs are 0; the FSM (to IDLE); mem_req, StallM and mem_err (to 0); and the timeout counter.
REQ-017 Reset during WAIT abandons the request. A mem_ack arriving after reset release is ignored per REQ-010, because no memory op is present.

Configuration
REQ-018 Macro MEM_TIMEOUT_EN.
- Defined: an 8-bit counter increments each cycle in WAIT. When it reaches TIMEOUT_CYCLES without mem_ack, the following happen in the same cycle:
  - mem_req drops.
  - mem_err sets (sticky until reset).
  - The op completes: a load writes back 32'h0, a store is discarded.
  - The FSM passes through ERR_WAIT for one cycle, then returns to IDLE.
  - If mem_ack and the timeout coincide, mem_ack wins.
- Undefined: no counter and no ERR_WAIT; WAIT persists indefinitely; mem_err is tied to 0.

Verification
REQ-019 ALU op RdE=5, ALUResultE=0x10, ResultSrcE=00 -> after 2 edges: ResultW=0x10, RdW=5, RegWriteW=1; mem_req stays 0.
REQ-020 Load with addr 0x103 and mem_ack held high -> mem_addr=0x100 in M cycle, StallM=0; next cycle ResultW=mem_rdata.
REQ-021 Store with addr 0x200, data 0xCAFEF00D, mem_ack delayed 3 cycles -> StallM=1 for 3 cycles, EX/MEM inputs ignored, addr/data stable, then 1 cycle with req+ack and StallM=0; MEM/WB holds bubbles during stall.
REQ-022 Load to RdE=0 -> RegWriteW=0.
REQ-023 `MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=4, load with mem_ack never asserted -> mem_req drops after 4 WAIT cycles, mem_err=1, ResultW=0, StallM released; second case with mem_ack on the timeout cycle -> mem_err stays 0.
REQ-024 rst_n pulsed low during WAIT -> mem_req, StallM, RegWriteW and mem_err go to 0 immediately; a late mem_ack causes no writeback.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake FSM and MEM/WB register.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic        mem_err
);

  // The timeout counter is 8 bits wide.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WAIT, ERR_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

  state_t      state, state_next;

  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] write_data_m;
  logic [31:0] pc_plus4_m;

  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic        reg_write_w;

  logic        mem_op;
  logic        is_load;
  logic        ack_eff;
  logic        timeout;
  logic        done;

  assign mem_op  = mem_write_m || (result_src_m == 2'b01);
  assign is_load = !mem_write_m && (result_src_m == 2'b01);

  // EX/MEM register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM    <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      RdM          <= 5'd0;
      ALUResultM   <= 32'd0;
      write_data_m <= 32'd0;
      pc_plus4_m   <= 32'd0;
    end else if (!StallM) begin
      RegWriteM    <= RegWriteE;
      mem_write_m  <= MemWriteE;
      result_src_m <= ResultSrcE;
      RdM          <= RdE;
      ALUResultM   <= ALUResultE;
      write_data_m <= WriteDataE;
      pc_plus4_m   <= PCPlus4E;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT && !ack_eff) ? tmo_cnt + 8'd1 : 8'd0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_req = 1'b1;
          if (!mem_ack) state_next = WAIT;
        end
      end
      WAIT: begin
        // Request stays up through the timeout cycle so a coinciding ack wins.
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = ERR_WAIT;
        end
`endif
      end
`ifdef MEM_TIMEOUT_EN
      ERR_WAIT: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign ack_eff = mem_req && mem_ack;
  assign done    = !mem_op || ack_eff || timeout;
  assign StallM  = !done;

  assign mem_we    = mem_write_m;
  assign mem_addr  = {ALUResultM[31:2], 2'b00};
  assign mem_wdata = write_data_m;

  // MEM/WB register: a stalled M slot hands a bubble to writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w  <= 1'b0;
      RdW          <= 5'd0;
      result_src_w <= 2'b00;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
      pc_plus4_w   <= 32'd0;
    end else if (StallM) begin
      reg_write_w <= 1'b0;
      RdW         <= 5'd0;
    end else begin
      reg_write_w  <= RegWriteM;
      RdW          <= RdM;
      result_src_w <= result_src_m;
      alu_result_w <= ALUResultM;
      pc_plus4_w   <= pc_plus4_m;
      if (is_load) read_data_w <= timeout ? 32'd0 : mem_rdata;
    end
  end

  always_comb begin
    case (result_src_w)
      2'b01:   ResultW = read_data_w;
      2'b10:   ResultW = pc_plus4_w;
      default: ResultW = alu_result_w;
    endcase
  end

  assign RegWriteW = reg_write_w && (RdW != 5'd0);

endmodule
